// File: rtl/ysyx_23060042_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencer.
package ysyx_23060042_pkg;

    typedef enum logic [2:0] {
        S_FETCH_REQ  = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_DECODE     = 3'd2,
        S_MEM_REQ    = 3'd3,
        S_MEM_WAIT   = 3'd4,
        S_WB         = 3'd5,
        S_HALT       = 3'd6,
        S_ERR        = 3'd7
    } state_e;

    localparam logic [1:0] MEM_NONE    = 2'b00;
    localparam int         CNT_W_DEF   = 64;
    localparam int         TIMEOUT_DEF = 1024;

    // A limit of 0 disables the timer but still needs a 1-bit counter.
    function automatic int timer_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ysyx_23060042_wait_timer.sv
// Bus-wait watchdog: counts cycles spent waiting and flags the last allowed one.
module ysyx_23060042_wait_timer
    import ysyx_23060042_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int             W    = timer_width(LIMIT);
    localparam logic [W-1:0]   LAST = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturates at LAST so a long wait with the timer disabled never wraps into a false expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (LIMIT > 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/ysyx_23060042_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode hold, memory access, writeback,
// with halt/timeout stop states and mcycle/minstret counters.
module ysyx_23060042_seq_ctrl
    import ysyx_23060042_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req_valid_o,
    input  logic             ifu_req_ready_i,
    input  logic             ifu_rsp_valid_i,
    input  logic [31:0]      ifu_rsp_inst_i,
    output logic [31:0]      inst_o,
    input  logic             regen_i,
    input  logic             pcjen_i,
    input  logic             pcren_i,
    input  logic [1:0]       mwen_i,
    input  logic [1:0]       mren_i,
    input  logic             brken_i,
    output logic             lsu_req_valid_o,
    output logic             lsu_req_we_o,
    input  logic             lsu_req_ready_i,
    input  logic             lsu_rsp_valid_i,
    output logic             rf_we_o,
    output logic             pc_we_o,
    output logic             inst_done_o,
    output logic             halt_o,
    output logic             err_o,
    output logic [CNT_W-1:0] mcycle_o,
    output logic [CNT_W-1:0] minstret_o
);

    state_e           state_q;
    logic [31:0]      inst_q;
    logic             ifu_req_valid_q;
    logic             lsu_req_valid_q;
    logic             lsu_req_we_q;
    logic             rf_we_q;
    logic             pc_we_q;
    logic             inst_done_q;
    logic             halt_q;
    logic             err_q;
    logic [CNT_W-1:0] mcycle_q;
    logic [CNT_W-1:0] minstret_q;

    logic in_wait;
    logic expired;
    logic unused_dec;

    // PC source selection belongs to the datapath; the sequencer only strobes pc_we.
    assign unused_dec = pcjen_i ^ pcren_i;
    assign in_wait    = (state_q == S_FETCH_WAIT) || (state_q == S_MEM_WAIT);

    ysyx_23060042_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (!in_wait),
        .en_i     (in_wait),
        .expired_o(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_FETCH_REQ;
            inst_q          <= '0;
            ifu_req_valid_q <= 1'b1;
            lsu_req_valid_q <= 1'b0;
            lsu_req_we_q    <= 1'b0;
            rf_we_q         <= 1'b0;
            pc_we_q         <= 1'b0;
            inst_done_q     <= 1'b0;
            halt_q          <= 1'b0;
            err_q           <= 1'b0;
            mcycle_q        <= '0;
            minstret_q      <= '0;
        end else begin
            rf_we_q     <= 1'b0;
            pc_we_q     <= 1'b0;
            inst_done_q <= 1'b0;
            if ((state_q != S_HALT) && (state_q != S_ERR)) begin
                mcycle_q <= mcycle_q + CNT_W'(1);
            end

            unique case (state_q)
                S_FETCH_REQ: begin
                    if (ifu_req_ready_i) begin
                        state_q         <= S_FETCH_WAIT;
                        ifu_req_valid_q <= 1'b0;
                    end
                end
                S_FETCH_WAIT: begin
                    if (ifu_rsp_valid_i) begin
                        inst_q  <= ifu_rsp_inst_i;
                        state_q <= S_DECODE;
                    end else if (expired) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                        halt_q  <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (brken_i) begin
                        state_q <= S_HALT;
                        halt_q  <= 1'b1;
                    end else if ((mwen_i | mren_i) != MEM_NONE) begin
                        state_q         <= S_MEM_REQ;
                        lsu_req_valid_q <= 1'b1;
                        lsu_req_we_q    <= |mwen_i;
                    end else begin
                        state_q     <= S_WB;
                        rf_we_q     <= regen_i;
                        pc_we_q     <= 1'b1;
                        inst_done_q <= 1'b1;
                    end
                end
                S_MEM_REQ: begin
                    if (lsu_req_ready_i) begin
                        state_q         <= S_MEM_WAIT;
                        lsu_req_valid_q <= 1'b0;
                        lsu_req_we_q    <= 1'b0;
                    end
                end
                S_MEM_WAIT: begin
                    if (lsu_rsp_valid_i) begin
                        state_q     <= S_WB;
                        rf_we_q     <= regen_i;
                        pc_we_q     <= 1'b1;
                        inst_done_q <= 1'b1;
                    end else if (expired) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                        halt_q  <= 1'b1;
                    end
                end
                S_WB: begin
                    state_q         <= S_FETCH_REQ;
                    ifu_req_valid_q <= 1'b1;
                    minstret_q      <= minstret_q + CNT_W'(1);
                end
                S_HALT, S_ERR: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    // NOTE: the flop resets to 1 so the request is up on the first cycle out of reset; the gate keeps it low while reset is held.
    assign ifu_req_valid_o = ifu_req_valid_q && !rst;
    assign lsu_req_valid_o = lsu_req_valid_q;
    assign lsu_req_we_o    = lsu_req_we_q;
    assign rf_we_o         = rf_we_q;
    assign pc_we_o         = pc_we_q;
    assign inst_done_o     = inst_done_q;
    assign halt_o          = halt_q;
    assign err_o           = err_q;
    assign inst_o          = inst_q;
    assign mcycle_o        = mcycle_q;
    assign minstret_o      = minstret_q;

endmodule
